// File: rtl/mem_ctrl.sv
// mem_ctrl: MAR/MDR memory interface controller with a fixed-latency SRAM
// handshake and an optional memory-mapped I/O location.
//
// Optional feature: define MEM_IO_EN to decode address 16'hFFFF as I/O
// (reads return the switches, writes update hex_out). Without it, 16'hFFFF
// is ordinary SRAM and hex_out stays 0.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous reset, active low
//   bus         datapath value loaded into MAR/MDR
//   load_mar    load MAR from bus (IDLE only)
//   load_mdr    load MDR from bus (IDLE only)
//   mem_req     start a transfer at MAR (IDLE only)
//   mem_we      transfer direction with mem_req: 1 write, 0 read
//   sram_rdata  SRAM read data
//   sw          switch inputs (I/O reads)
//   mar, mdr    address / data registers
//   sram_addr   SRAM address (= mar)
//   sram_wdata  SRAM write data (= mdr)
//   sram_oe     SRAM read strobe
//   sram_we     SRAM write strobe
//   busy        high while not IDLE
//   mem_ready   one-cycle transfer-complete pulse
//   hex_out     memory-mapped display register
module mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus,
  input  logic        load_mar,
  input  logic        load_mdr,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] sram_rdata,
  input  logic [9:0]  sw,
  output logic [15:0] mar,
  output logic [15:0] mdr,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_oe,
  output logic        sram_we,
  output logic        busy,
  output logic        mem_ready,
  output logic [15:0] hex_out
);

  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 4;
  localparam int unsigned SWW = 10;
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);
  localparam logic [DW-1:0] IO_ADDR  = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_mar;
  logic [DW-1:0] r_mdr;
  logic [DW-1:0] r_hex;
  logic          r_oe;
  logic          r_we;
  logic          r_busy;
  logic          r_ready;
  logic          r_io;

  // Address the transfer will use: a same-cycle MAR load wins.
  logic [DW-1:0] w_addr_next;
  logic          w_io_sel;
  logic [DW-1:0] w_io_rdata;

  assign w_addr_next = load_mar ? bus : r_mar;

`ifdef MEM_IO_EN
  assign w_io_sel   = (w_addr_next == IO_ADDR);
  assign w_io_rdata = {(DW-SWW)'(0), sw};
`else
  logic w_unused_sw;
  logic [DW-1:0] w_unused_addr;
  assign w_io_sel      = 1'b0;
  assign w_io_rdata    = '0;
  assign w_unused_sw   = ^sw;
  assign w_unused_addr = IO_ADDR;
`endif

  // Controller FSM; strobes, busy and mem_ready update with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_hex   <= '0;
      r_oe    <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_io    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_mar) r_mar <= bus;
          if (load_mdr) r_mdr <= bus;
          if (mem_req) begin
            r_cnt  <= '0;
            r_io   <= w_io_sel;
            r_busy <= 1'b1;
            if (mem_we) begin
              r_state <= WR_WAIT;
              r_we    <= !w_io_sel;
            end else begin
              r_state <= RD_WAIT;
              r_oe    <= !w_io_sel;
            end
          end
        end
        RD_WAIT: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= DONE;
            r_oe    <= 1'b0;
            r_ready <= 1'b1;
            r_mdr   <= r_io ? w_io_rdata : sram_rdata;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        WR_WAIT: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= DONE;
            r_we    <= 1'b0;
            r_ready <= 1'b1;
            // r_io is only ever set when MEM_IO_EN decodes the I/O address.
            if (r_io) r_hex <= r_mdr;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_oe    <= 1'b0;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mar        = r_mar;
  assign mdr        = r_mdr;
  assign sram_addr  = r_mar;
  assign sram_wdata = r_mdr;
  assign sram_oe    = r_oe;
  assign sram_we    = r_we;
  assign busy       = r_busy;
  assign mem_ready  = r_ready;
  assign hex_out    = r_hex;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. Directed transfer vectors
// from a table plus hand sequences for lockout, same-cycle load+request,
// back-to-back requests and reset abort. Build with MEM_IO_EN defined to
// exercise the I/O location.
module tb_mem_ctrl;

  localparam int unsigned WAIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus;
  logic        load_mar;
  logic        load_mdr;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] sram_rdata;
  logic [9:0]  sw;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic [15:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_oe;
  logic        sram_we;
  logic        busy;
  logic        mem_ready;
  logic [15:0] hex_out;

  int n_checks = 0;
  int n_fail   = 0;

  mem_ctrl #(.WAIT_CYCLES(WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .load_mar   (load_mar),
    .load_mdr   (load_mdr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .sram_rdata (sram_rdata),
    .sw         (sw),
    .mar        (mar),
    .mdr        (mdr),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_oe    (sram_oe),
    .sram_we    (sram_we),
    .busy       (busy),
    .mem_ready  (mem_ready),
    .hex_out    (hex_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] exp_mdr;
    logic [15:0] exp_hex;
    int          exp_oe;
    int          exp_we;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Load MAR (and MDR for writes), issue one request, watch 8 cycles.
  task automatic run_txn(input vec_t v, input int idx);
    int oe_n, we_n, rdy_n, lat;
    logic both;
    logic [15:0] a_s, w_s;
    oe_n = 0; we_n = 0; rdy_n = 0; lat = 0; both = 1'b0; a_s = '0; w_s = '0;
    @(negedge clk); load_mar = 1'b1; bus = v.addr;
    @(negedge clk); load_mar = 1'b0; load_mdr = v.we; bus = v.wdata;
    @(negedge clk); load_mdr = 1'b0; mem_req = 1'b1; mem_we = v.we; sram_rdata = v.rdata;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      mem_req = 1'b0;
      if (k == 1) begin a_s = sram_addr; w_s = sram_wdata; end
      if (sram_oe) oe_n++;
      if (sram_we) we_n++;
      if (sram_oe && sram_we) both = 1'b1;
      if (mem_ready) begin
        rdy_n++;
        if (lat == 0) lat = k;
      end
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(WAIT + 1));
    chk($sformatf("v%0d_ready_pulses", idx), 32'(rdy_n), 32'd1);
    chk($sformatf("v%0d_oe_cycles", idx), 32'(oe_n), 32'(v.exp_oe));
    chk($sformatf("v%0d_we_cycles", idx), 32'(we_n), 32'(v.exp_we));
    chk($sformatf("v%0d_strobe_overlap", idx), 32'(both), 32'd0);
    chk($sformatf("v%0d_mdr", idx), 32'(mdr), 32'(v.exp_mdr));
    chk($sformatf("v%0d_mar", idx), 32'(mar), 32'(v.addr));
    chk($sformatf("v%0d_sram_addr", idx), 32'(a_s), 32'(v.addr));
    chk($sformatf("v%0d_hex", idx), 32'(hex_out), 32'(v.exp_hex));
    chk($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
    if (v.we) chk($sformatf("v%0d_sram_wdata", idx), 32'(w_s), 32'(v.wdata));
  endtask

  initial begin
    int rdy_n, oe_n, r1, r2;
    logic [15:0] a_s;

    //         we    addr      wdata     rdata     exp_mdr   exp_hex  oe we
    vecs[0] = '{1'b0, 16'h3000, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000, 2, 0};
    vecs[1] = '{1'b1, 16'h0010, 16'h1234, 16'h5555, 16'h1234, 16'h0000, 0, 2};
    vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2, 0};
    vecs[3] = '{1'b0, 16'h8001, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 2, 0};
    vecs[4] = '{1'b1, 16'hFFFE, 16'hA5A5, 16'h0000, 16'hA5A5, 16'h0000, 0, 2};
`ifdef MEM_IO_EN
    vecs[5] = '{1'b0, 16'hFFFF, 16'h0000, 16'h1357, 16'h02A5, 16'h0000, 0, 0};
    vecs[6] = '{1'b1, 16'hFFFF, 16'h00C3, 16'h0000, 16'h00C3, 16'h00C3, 0, 0};
`else
    vecs[5] = '{1'b0, 16'hFFFF, 16'h0000, 16'h1357, 16'h1357, 16'h0000, 2, 0};
    vecs[6] = '{1'b1, 16'hFFFF, 16'h00C3, 16'h0000, 16'h00C3, 16'h0000, 0, 2};
`endif

    reset = 1'b0; bus = 16'h5A5A; load_mar = 1'b1; load_mdr = 1'b1; mem_req = 1'b1;
    mem_we = 1'b0; sram_rdata = 16'h0000; sw = 10'h2A5;
    repeat (3) @(negedge clk);
    chk("reset_mar", 32'(mar), 32'd0);
    chk("reset_mdr", 32'(mdr), 32'd0);
    chk("reset_hex", 32'(hex_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_strobes", 32'({sram_oe, sram_we}), 32'd0);
    chk("reset_ready", 32'(mem_ready), 32'd0);
    reset = 1'b1; load_mar = 1'b0; load_mdr = 1'b0; mem_req = 1'b0; bus = '0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Same-cycle MAR load and request uses the new address.
    @(negedge clk); load_mar = 1'b1; bus = 16'h0042; mem_req = 1'b1; mem_we = 1'b0;
    sram_rdata = 16'h4242;
    @(negedge clk); load_mar = 1'b0; mem_req = 1'b0; a_s = sram_addr;
    chk("combo_addr", 32'(a_s), 32'h0042);
    chk("combo_oe", 32'(sram_oe), 32'd1);
    repeat (3) @(negedge clk);
    chk("combo_mdr", 32'(mdr), 32'h4242);

    // Lockout: loads during RD_WAIT and a request during DONE are dropped.
    @(negedge clk); load_mar = 1'b1; bus = 16'h3000;
    @(negedge clk); load_mar = 1'b0; mem_req = 1'b1; mem_we = 1'b0; sram_rdata = 16'h1111;
    @(negedge clk); mem_req = 1'b0; load_mar = 1'b1; load_mdr = 1'b1; bus = 16'hAAAA;
    @(negedge clk); load_mar = 1'b0; load_mdr = 1'b0;
    @(negedge clk);
    chk("lock_ready_in_done", 32'(mem_ready), 32'd1);
    mem_req = 1'b1;
    @(negedge clk); mem_req = 1'b0;
    chk("lock_busy_after_done", 32'(busy), 32'd0);
    oe_n = 0;
    for (int k = 0; k < 4; k++) begin
      if (sram_oe || sram_we || busy) oe_n++;
      @(negedge clk);
    end
    chk("lock_no_second_txn", 32'(oe_n), 32'd0);
    chk("lock_mar", 32'(mar), 32'h3000);
    chk("lock_mdr", 32'(mdr), 32'h1111);

    // Back-to-back: request held high gives one completion every WAIT+2.
    mem_req = 1'b1; mem_we = 1'b0; sram_rdata = 16'h7777;
    rdy_n = 0; r1 = 0; r2 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_ready) begin
        rdy_n++;
        if (r1 == 0) r1 = k; else if (r2 == 0) r2 = k;
      end
    end
    mem_req = 1'b0;
    chk("b2b_pulses", 32'(rdy_n), 32'd3);
    chk("b2b_first", 32'(r1), 32'(WAIT + 1));
    chk("b2b_period", 32'(r2 - r1), 32'(WAIT + 2));
    repeat (6) @(negedge clk);

    // Abort: reset in the first RD_WAIT cycle.
    @(negedge clk); load_mar = 1'b1; bus = 16'h3000;
    @(negedge clk); load_mar = 1'b0; mem_req = 1'b1; mem_we = 1'b0; sram_rdata = 16'hDEAD;
    @(negedge clk); mem_req = 1'b0;
    chk("abort_in_rd_wait", 32'(sram_oe), 32'd1);
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_oe", 32'(sram_oe), 32'd0);
    chk("abort_mdr", 32'(mdr), 32'd0);
    chk("abort_mar", 32'(mar), 32'd0);
    rdy_n = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_ready || busy) rdy_n++;
    end
    chk("abort_no_ready", 32'(rdy_n), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning SRAM access wait cycles per transfer; legal range 1..15.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port bus  input  16  datapath bus value for MAR/MDR loads.
REQ-005 SHALL have port load_mar  input  1  load MAR from bus.
REQ-006 SHALL have port load_mdr  input  1  load MDR from bus.
REQ-007 SHALL have port mem_req  input  1  start memory transfer at MAR.
REQ-008 SHALL have port mem_we  input  1  transfer direction, sampled with mem_req: 1 write, 0 read.
REQ-009 SHALL have port sram_rdata  input  16  SRAM read data.
REQ-010 SHALL have port sw  input  10  switch inputs for memory-mapped I/O.
REQ-011 SHALL have port mar  output  16  MAR register.
REQ-012 SHALL have port mdr  output  16  MDR register; feeds bus mux MDR input.
REQ-013 SHALL have port sram_addr  output  16  equals mar at all times.
REQ-014 SHALL have port sram_wdata  output  16  equals mdr at all times.
REQ-015 SHALL have port sram_oe  output  1  SRAM read strobe.
REQ-016 SHALL have port sram_we  output  1  SRAM write strobe.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-018 SHALL have port mem_ready  output  1  one-cycle transfer-complete pulse.
REQ-019 SHALL have port hex_out  output  16  memory-mapped display register.

Function
REQ-020 SHALL implement states IDLE, RD_WAIT, WR_WAIT, DONE, with a 4-bit wait counter.
REQ-021 SHALL, in IDLE only, load mar<=bus on load_mar and mdr<=bus on load_mdr; both may load in the same cycle.
REQ-022 SHALL ignore load_mar, load_mdr and mem_req in any non-IDLE state, with no queuing.
REQ-023 SHALL, on mem_req in IDLE, go to RD_WAIT (mem_we=0) or WR_WAIT (mem_we=1) and clear the counter.
REQ-024 SHALL, on load_mar and mem_req in the same IDLE cycle, access the newly loaded MAR value.
REQ-025 SHALL hold sram_oe high in every RD_WAIT cycle and sram_we high in every WR_WAIT cycle; both are low elsewhere and never high together.
REQ-026 SHALL leave RD_WAIT/WR_WAIT after exactly WAIT_CYCLES cycles; on the RD_WAIT exit edge, mdr<=sram_rdata.
REQ-027 SHALL stay in DONE exactly one cycle with mem_ready=1, then return to IDLE; request-to-mem_ready latency is WAIT_CYCLES+1 cycles.
REQ-028 SHALL leave mdr unchanged by writes and mar unchanged by any transfer.
REQ-029 SHALL accept a new mem_req no earlier than the cycle after DONE (back-to-back period WAIT_CYCLES+2).

Reset
REQ-030 SHALL, when reset=0 at a clock edge, set state IDLE, counter 0, mar=0, mdr=0, hex_out=0.
REQ-031 SHALL drive sram_oe=0, sram_we=0, busy=0 and mem_ready=0 from the cycle after a reset edge.
REQ-032 SHALL treat reset during RD_WAIT/WR_WAIT/DONE as an abort: no mdr capture and no mem_ready pulse.
REQ-033 SHALL give reset priority over all loads and requests in the same cycle.

Configuration
REQ-034 SHALL, with macro MEM_IO_EN defined, decode mar==16'hFFFF as I/O: reads capture {6'b0,sw} into mdr; writes load hex_out<=mdr.
REQ-035 SHALL, with MEM_IO_EN defined, keep the same state sequence and timing for I/O accesses but hold sram_oe and sram_we low.
REQ-036 SHALL, without MEM_IO_EN, treat 16'hFFFF as ordinary SRAM, ignore sw, and tie hex_out to 0; ports are unchanged.

Verification
REQ-037 SHALL check read: bus=0x3000 with load_mar, then mem_req, mem_we=0, sram_rdata=0xBEEF -> sram_oe high 2 cycles, mdr=0xBEEF, mem_ready pulse 3 cycles after request.
REQ-038 SHALL check write: mar=0x0010, bus=0x1234 with load_mdr, then mem_req, mem_we=1 -> sram_we high 2 cycles, sram_addr=0x0010, sram_wdata=0x1234, mdr unchanged.
REQ-039 SHALL check busy lockout: load_mar with bus=0xAAAA during RD_WAIT -> mar unchanged; second mem_req during DONE -> ignored.
REQ-040 SHALL check abort: reset=0 in first RD_WAIT cycle -> mdr=0, no mem_ready, IDLE next cycle.
REQ-041 SHALL check MEM_IO_EN: mar=0xFFFF, sw=0x2A5, read -> mdr=0x02A5, sram_oe never high; write with mdr=0x00C3 -> hex_out=0x00C3.
